// File: rtl/store_retire_buffer.sv
// rtl/store_retire_buffer.sv - post-commit store FIFO with drain FSM and optional load forwarding (STORE_BUF_FWD_EN)
module store_retire_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          retire_store_valid,
    input  logic [AW-1:0] retire_store_addr,
    input  logic [DW-1:0] retire_store_data,
    output logic          sb_full,
    output logic          sb_empty,
    output logic          sb_ovf_err,
    output logic          mem_wr_req,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic          mem_wr_ack,
    input  logic          ld_chk_valid,
    input  logic [AW-1:0] ld_chk_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          push;
    logic          pop;
    logic          load_head;

    // Full is judged on the registered count, so a push in the same cycle as a pop from a full buffer is still dropped
    assign sb_full  = (count == FULL_CNT);
    assign sb_empty = (count == '0) && (state == S_IDLE);
    assign push     = retire_store_valid && !sb_full;

    // Drain FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next state: start a write whenever something is buffered, finish on ack
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (count != '0) state_nxt = S_WRITE;
            S_WRITE: if (mem_wr_ack)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM outputs: capture the head in IDLE, pop only on ack while writing
    always_comb begin
        load_head = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE:  load_head = (count != '0);
            S_WRITE: pop       = mem_wr_ack;
            default: begin
                load_head = 1'b0;
                pop       = 1'b0;
            end
        endcase
    end

    // Registered write request; addr/data are held stable for the whole WRITE state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else if (load_head) begin
            mem_wr_req  <= 1'b1;
            mem_wr_addr <= addr_mem[rd_ptr];
            mem_wr_data <= data_mem[rd_ptr];
        end else if (pop) begin
            mem_wr_req  <= 1'b0;
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr so no reset is needed
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= retire_store_addr;
            data_mem[wr_ptr] <= retire_store_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag: any retire attempt while full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb_ovf_err <= 1'b0;
        end else if (retire_store_valid && sb_full) begin
            sb_ovf_err <= 1'b1;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] scan_idx;

    // Forwarding lookup: scan oldest to youngest so the last match (youngest) wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if (ld_chk_valid && ((PW+1)'(i) < count) && (addr_mem[scan_idx] == ld_chk_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[scan_idx];
            end
        end
    end
`else
    logic unused_ld_chk;

    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
    assign unused_ld_chk = ^{ld_chk_valid, ld_chk_addr};
`endif

endmodule
